// File: rtl/build_info_pkg.sv
// Shared types and helpers for the build-info UART reporter.
package build_info_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BYTE,
    FINISH
  } state_e;

  localparam int unsigned MSG_LEN  = 33;
  localparam logic [5:0]  LAST_IDX = 6'(MSG_LEN - 1);

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; each bit is held DIV clock cycles, line idles high.
module uart_tx_byte #(
  parameter int unsigned DIV = 868
) (
  input  logic       clk100,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int unsigned    CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(DIV - 1);

  logic          active_q, active_d;
  logic [9:0]    sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          bit_end, frame_end;

  // ready also rises in the final stop-bit cycle so a waiting byte can follow without a gap
  always_comb begin
    bit_end   = active_q && (baud_q == BAUD_LAST);
    frame_end = bit_end && (bit_q == 4'd9);
    ready_o   = !active_q || frame_end;
    active_d  = active_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    baud_d    = baud_q;
    tx_d      = tx_q;
    if (valid_i && ready_o) begin
      active_d = 1'b1;
      sh_d     = {1'b1, data_i, 1'b0};
      bit_d    = '0;
      baud_d   = '0;
      tx_d     = 1'b0;
    end else if (frame_end) begin
      active_d = 1'b0;
      bit_d    = '0;
      baud_d   = '0;
      tx_d     = 1'b1;
    end else if (bit_end) begin
      baud_d = '0;
      bit_d  = bit_q + 4'd1;
      sh_d   = {1'b1, sh_q[9:1]};
      tx_d   = sh_q[1];
    end else if (active_q) begin
      baud_d = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      sh_q     <= '1;
      bit_q    <= '0;
      baud_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      tx_q     <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: rtl/build_info_uart.sv
// Sends "GH=<16 hex> TS=<8 hex>\r\n" over UART once per accepted start request.
module build_info_uart
  import build_info_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic [63:0] git_hash_i,
  input  logic [31:0] timestamp_i,
  input  logic        start_i,
  output logic        tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [63:0] hash_q, hash_d;
  logic [31:0] ts_q, ts_d;
  logic        armed_q, armed_d;
  logic        done_q, done_d;
  logic        accept;
  logic        tx_valid, tx_ready;
  logic [7:0]  byte_data;
  logic [3:0]  hnib;
  logic [2:0]  tnib;
  logic [63:0] hash_sh;
  logic [31:0] ts_sh;

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hash_q  <= '0;
      ts_q    <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hash_q  <= hash_d;
      ts_q    <= ts_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  // armed_q keeps start_i blind for the first cycle after reset release
  always_comb begin
    accept  = (state_q == IDLE) && start_i && armed_q;
    state_d = state_q;
    idx_d   = idx_q;
    hash_d  = hash_q;
    ts_d    = ts_q;
    armed_d = 1'b1;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SEND;
        idx_d   = '0;
        hash_d  = git_hash_i;
        ts_d    = timestamp_i;
      end
      SEND: if (tx_ready) state_d = WAIT_BYTE;
      WAIT_BYTE: if (tx_ready) begin
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else begin
          state_d = SEND;
          idx_d   = idx_q + 6'd1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != IDLE);
    tx_valid = (state_q == SEND);
    done_d   = (state_q == FINISH);
  end

  // Shifting the snapshot left by the digit position puts the wanted nibble on top
  always_comb begin
    hnib    = 4'(idx_q - 6'd3);
    tnib    = 3'(idx_q - 6'd23);
    hash_sh = hash_q << {hnib, 2'b00};
    ts_sh   = ts_q << {tnib, 2'b00};
    case (idx_q) inside
      6'd0:            byte_data = 8'h47;
      6'd1:            byte_data = 8'h48;
      6'd2:            byte_data = 8'h3D;
      [6'd3:6'd18]:    byte_data = nib2ascii(hash_sh[63:60]);
      6'd19:           byte_data = 8'h20;
      6'd20:           byte_data = 8'h54;
      6'd21:           byte_data = 8'h53;
      6'd22:           byte_data = 8'h3D;
      [6'd23:6'd30]:   byte_data = nib2ascii(ts_sh[31:28]);
      6'd31:           byte_data = 8'h0D;
      default:         byte_data = 8'h0A;
    endcase
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_tx (
    .clk100  (clk100),
    .rst     (rst),
    .data_i  (byte_data),
    .valid_i (tx_valid),
    .ready_o (tx_ready),
    .tx_o    (tx_o)
  );

  assign done_o = done_q;

endmodule

// File: tb/tb_build_info_uart.sv
// Bench for build_info_uart at DIV=10: UART monitor feeds a receive queue checked against expected bytes.
module tb_build_info_uart;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [63:0] git_hash_i = '0;
  logic [31:0] timestamp_i = '0;
  logic        tx_o, busy_o, done_o;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int unsigned frame_err = 0;
  int unsigned done_cnt = 0;
  int unsigned done_dbl = 0;

  always #5 clk100 = ~clk100;

  build_info_uart #(
    .CLK_FREQ_HZ(1000),
    .BAUD(100)
  ) dut (
    .clk100      (clk100),
    .rst         (rst),
    .git_hash_i  (git_hash_i),
    .timestamp_i (timestamp_i),
    .start_i     (start_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  // UART receiver: samples each cycle, requires every bit to be flat for 10 samples
  initial begin
    bit          mon_on = 1'b0;
    bit          prev_done = 1'b0;
    int unsigned mon_cyc = 0;
    logic        mon_cur = 1'b0;
    logic [7:0]  mon_byte = '0;
    forever begin
      @(negedge clk100);
      if (rst) begin
        mon_on    = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (done_o === 1'b1) begin
          done_cnt++;
          if (prev_done) done_dbl++;
        end
        prev_done = (done_o === 1'b1);
        if (!mon_on) begin
          if (tx_o === 1'b0) begin
            mon_on  = 1'b1;
            mon_cyc = 1;
            mon_cur = 1'b0;
          end
        end else begin
          if (mon_cyc % 10 == 0) begin
            mon_cur = tx_o;
            if (mon_cyc / 10 >= 1 && mon_cyc / 10 <= 8) mon_byte[mon_cyc/10-1] = tx_o;
          end else if (tx_o !== mon_cur) begin
            frame_err++;
          end
          mon_cyc++;
          if (mon_cyc == 100) begin
            if (mon_cur !== 1'b1) frame_err++;
            rx_q.push_back(mon_byte);
            mon_on = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic push_report(input logic [63:0] h, input logic [31:0] t);
    exp_q.push_back(8'h47); exp_q.push_back(8'h48); exp_q.push_back(8'h3D);
    for (int i = 15; i >= 0; i--) exp_q.push_back(hexc(h[i*4 +: 4]));
    exp_q.push_back(8'h20); exp_q.push_back(8'h54); exp_q.push_back(8'h53); exp_q.push_back(8'h3D);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(t[i*4 +: 4]));
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic start_pulse();
    @(negedge clk100) start_i = 1'b1;
    @(posedge clk100);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    bit found = 1'b0;
    for (int unsigned i = 0; i < budget && !found; i++) begin
      @(negedge clk100);
      if (done_o === 1'b1) found = 1'b1;
    end
    n_total++;
    if (!found) $display("FAIL %s: done_o not seen within %0d cycles", name, budget);
    else n_pass++;
  endtask

  task automatic wait_rx(input string name, input int unsigned n, input int unsigned budget);
    int unsigned i = 0;
    while (rx_q.size() < n && i < budget) begin
      @(negedge clk100);
      i++;
    end
    n_total++;
    if (rx_q.size() < n) $display("FAIL %s: received %0d bytes, required %0d", name, rx_q.size(), n);
    else n_pass++;
  endtask

  task automatic compare_rx(input string name);
    int unsigned k = 0;
    logic [7:0] e, r;
    while (exp_q.size() > 0) begin
      n_total++;
      e = exp_q.pop_front();
      if (rx_q.size() == 0) begin
        $display("FAIL %s byte %0d: nothing received, expected 0x%02h", name, k, e);
        exp_q.delete();
      end else begin
        r = rx_q.pop_front();
        if (r !== e) $display("FAIL %s byte %0d: got 0x%02h expected 0x%02h", name, k, r, e);
        else n_pass++;
      end
      k++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk100);
    n_total++; if (tx_o !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_o); else n_pass++;
    start_i = 1'b1;
    rst = 1'b0;
    @(posedge clk100);
    #1;
    n_total++; if (busy_o !== 1'b0) $display("FAIL start_after_reset_ignored: busy %b expected 0", busy_o); else n_pass++;
    @(negedge clk100) start_i = 1'b0;
    repeat (3) @(negedge clk100);
    n_total++; if (busy_o !== 1'b0) $display("FAIL post_reset_idle: busy %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_basic();
    int unsigned d0 = done_cnt;
    int unsigned len = 0;
    bit found = 1'b0;
    git_hash_i  = 64'h0123_4567_89AB_CDEF;
    timestamp_i = 32'h65A1_B2C3;
    push_report(git_hash_i, timestamp_i);
    start_pulse();
    n_total++; if (busy_o !== 1'b1) $display("FAIL basic_busy_rise: got %b expected 1", busy_o); else n_pass++;
    n_total++; if (tx_o !== 1'b1) $display("FAIL basic_tx_first_cycle: got %b expected 1", tx_o); else n_pass++;
    @(posedge clk100);
    #1;
    n_total++; if (tx_o !== 1'b0) $display("FAIL basic_start_bit: got %b expected 0", tx_o); else n_pass++;
    for (int unsigned i = 0; i < 4000 && !found; i++) begin
      @(negedge clk100);
      if (done_o === 1'b1) found = 1'b1;
      else len++;
    end
    n_total++; if (!found) $display("FAIL basic_done: not seen within 4000 cycles"); else n_pass++;
    n_total++;
    if (len < 3266 || len > 3334) $display("FAIL basic_length: got %0d cycles expected 3266..3334", len);
    else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL basic_busy_fall: got %b expected 0", busy_o); else n_pass++;
    repeat (50) @(negedge clk100);
    compare_rx("basic");
    n_total++; if (frame_err != 0) $display("FAIL basic_framing: got %0d errors expected 0", frame_err); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0); else n_pass++;
    n_total++; if (done_dbl != 0) $display("FAIL basic_done_width: got %0d long pulses expected 0", done_dbl); else n_pass++;
  endtask

  task automatic test_snapshot();
    git_hash_i  = 64'h0123_4567_89AB_CDEF;
    timestamp_i = 32'h65A1_B2C3;
    push_report(git_hash_i, timestamp_i);
    start_pulse();
    wait_rx("snapshot_progress", 6, 1000);
    git_hash_i  = '1;
    timestamp_i = '0;
    wait_done("snapshot_done", 4000);
    repeat (5) @(negedge clk100);
    compare_rx("snapshot");
  endtask

  task automatic test_busy_ignore();
    int unsigned d0 = done_cnt;
    git_hash_i  = 64'hDEAD_BEEF_0BAD_F00D;
    timestamp_i = 32'h1234_5678;
    push_report(git_hash_i, timestamp_i);
    start_pulse();
    wait_rx("ignore_progress", 10, 1500);
    @(negedge clk100) start_i = 1'b1;
    @(negedge clk100) start_i = 1'b0;
    wait_done("ignore_done", 4000);
    repeat (300) @(negedge clk100);
    compare_rx("ignore");
    n_total++; if (rx_q.size() != 0) $display("FAIL ignore_extra_bytes: got %0d expected 0", rx_q.size()); else n_pass++;
    n_total++; if (done_cnt - d0 != 1) $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - d0); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL ignore_busy: got %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned d0 = done_cnt;
    logic [63:0] h2 = {$urandom(), $urandom()};
    logic [31:0] t2 = $urandom();
    git_hash_i  = 64'h0F1E_2D3C_4B5A_6978;
    timestamp_i = 32'hA5A5_5A5A;
    push_report(git_hash_i, timestamp_i);
    push_report(h2, t2);
    @(negedge clk100) start_i = 1'b1;
    @(posedge clk100);
    #1;
    git_hash_i  = h2;
    timestamp_i = t2;
    wait_done("b2b_done1", 4000);
    n_total++; if (busy_o !== 1'b0) $display("FAIL b2b_busy_at_done: got %b expected 0", busy_o); else n_pass++;
    @(posedge clk100);
    #1;
    n_total++; if (busy_o !== 1'b1) $display("FAIL b2b_restart: busy %b expected 1", busy_o); else n_pass++;
    start_i = 1'b0;
    wait_done("b2b_done2", 4000);
    repeat (20) @(negedge clk100);
    compare_rx("b2b");
    n_total++; if (done_cnt - d0 != 2) $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_hex_af();
    git_hash_i  = 64'hABCD_EF00_0000_0000;
    timestamp_i = 32'h0;
    push_report(git_hash_i, timestamp_i);
    start_pulse();
    wait_done("hex_done", 4000);
    repeat (5) @(negedge clk100);
    compare_rx("hex_af");
    n_total++; if (frame_err != 0) $display("FAIL hex_framing: got %0d errors expected 0", frame_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int unsigned d0;
    git_hash_i  = 64'hABCD_EF00_0000_0000;
    timestamp_i = 32'h0;
    push_report(git_hash_i, timestamp_i);
    while (exp_q.size() > 20) void'(exp_q.pop_back());
    start_pulse();
    wait_rx("rstmid_progress", 20, 2500);
    repeat (35) @(negedge clk100);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    n_total++; if (tx_o !== 1'b1) $display("FAIL rstmid_tx: got %b expected 1", tx_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_o); else n_pass++;
    repeat (2) @(negedge clk100);
    rst = 1'b0;
    repeat (400) @(negedge clk100);
    compare_rx("rstmid");
    n_total++; if (rx_q.size() != 0) $display("FAIL rstmid_no_resume: got %0d bytes expected 0", rx_q.size()); else n_pass++;
    n_total++; if (done_cnt != d0) $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_cnt - d0); else n_pass++;
    n_total++; if (tx_o !== 1'b1) $display("FAIL rstmid_idle_tx: got %b expected 1", tx_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_busy_ignore();
    test_back_to_back();
    test_hex_af();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
